// File: rtl/cvs_loopback_pkg.sv
// ---------------------------------------------------------------------------
// cvs_loopback_pkg
// Shared types and constants for the CVS loopback tester slice.
//   state_t    : tester FSM states
//   LFSR_SEED  : reload value of the PRBS generator (never zero)
//   LFSR_TAPS  : feedback taps of x^5 + x^3 + 1 (state bits 4 and 2)
//   lfsr_step  : one shift of the 5-bit Fibonacci LFSR
// ---------------------------------------------------------------------------
package cvs_loopback_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ALIGN = 3'd2,
    CHECK = 3'd3,
    FAIL  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [4:0] LFSR_SEED = 5'h01;
  localparam logic [4:0] LFSR_TAPS = 5'b10100;

  // Shift left and feed the XOR of the tapped bits into bit 0. The polynomial
  // is primitive, so every non-zero seed walks all 31 non-zero states.
  function automatic logic [4:0] lfsr_step(input logic [4:0] s);
    return {s[3:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cvs_pattern_gen.sv
// ---------------------------------------------------------------------------
// cvs_pattern_gen
// Word source for the loopback tester. The output word is registered and is
// driven straight onto tx by the top.
// Build option: define LOOPBACK_PRBS_EN for a 5-bit PRBS (x^5+x^3+1, seed
// 5'h01); otherwise a WIDTH-bit binary up-counter starting at 0.
// Ports:
//   clk    in   1      test clock
//   rst_n  in   1      async active-low reset
//   load   in   1      reseed; next word is the first word of the sequence
//   run    in   1      emit the next word of the sequence
//   word   out  WIDTH  registered word, 0 whenever neither load nor run
// ---------------------------------------------------------------------------
module cvs_pattern_gen #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  output logic [WIDTH-1:0] word
);
  import cvs_loopback_pkg::*;

`ifdef LOOPBACK_PRBS_EN
  logic [4:0] lfsr_q;

  // lfsr_q always holds the word to emit next. Loading presents the seed at
  // once and pre-steps the state; when halted the output is forced to 0 while
  // the LFSR state simply waits for the next reseed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      word   <= '0;
    end else if (load) begin
      word   <= WIDTH'(LFSR_SEED);
      lfsr_q <= lfsr_step(LFSR_SEED);
    end else if (run) begin
      word   <= WIDTH'(lfsr_q);
      lfsr_q <= lfsr_step(lfsr_q);
    end else begin
      word   <= '0;
    end
  end
`else
  logic [WIDTH-1:0] cnt_q;

  // Same structure as the PRBS build: cnt_q is the next word, loading emits
  // 0 and primes 1, the counter wraps freely at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      word  <= '0;
    end else if (load) begin
      word  <= '0;
      cnt_q <= WIDTH'(1);
    end else if (run) begin
      word  <= cnt_q;
      cnt_q <= cnt_q + WIDTH'(1);
    end else begin
      word  <= '0;
    end
  end
`endif

endmodule

// File: rtl/cvs_loopback_tester.sv
// ---------------------------------------------------------------------------
// cvs_loopback_tester
// Stimulus/check end of the CVS loopback path. Drives a known word stream on
// tx, receives it back on rx, finds the path latency and then counts word
// mismatches. Build option LOOPBACK_PRBS_EN (see cvs_pattern_gen) selects the
// PRBS source instead of the counter.
// Ports:
//   clk         in   1      test clock
//   rst_n       in   1      async active-low reset
//   start       in   1      begin a run (ignored while busy)
//   stop        in   1      end a run, results held
//   tx          out  WIDTH  generated word (registered)
//   rx          in   WIDTH  returned word
//   busy        out  1      FILL, ALIGN or CHECK
//   locked      out  1      latency found, checking active / held
//   fail        out  1      no latency 0..MAX_LAT matched
//   latency     out  5      measured latency in cycles
//   err_count   out  CNT_W  mismatched words in CHECK, saturating
//   word_count  out  CNT_W  words compared in CHECK, saturating
// ---------------------------------------------------------------------------
module cvs_loopback_tester #(
  parameter int WIDTH       = 5,
  parameter int MAX_LAT     = 15,
  parameter int ALIGN_MATCH = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] tx,
  input  logic [WIDTH-1:0] rx,
  output logic             busy,
  output logic             locked,
  output logic             fail,
  output logic [4:0]       latency,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);
  import cvs_loopback_pkg::*;

  localparam int MW = $clog2(ALIGN_MATCH + 1);

  state_t           state_q, state_d;
  logic [4:0]       lat_q, lat_d;
  logic [4:0]       fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic             locked_d, fail_d;
  logic [4:0]       latency_d;
  logic [CNT_W-1:0] err_d, word_d;
  logic             load, run, busy_d, hit;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] hist [0:MAX_LAT];
  logic [WIDTH-1:0] hist_sel;

  cvs_pattern_gen #(.WIDTH(WIDTH)) u_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .run   (run),
    .word  (tx)
  );

  assign busy   = (state_q == FILL) || (state_q == ALIGN) || (state_q == CHECK);
  assign busy_d = (state_d == FILL) || (state_d == ALIGN) || (state_d == CHECK);
  // The generator steps only while the next state is busy, so tx drops to 0
  // on the same edge that leaves the run.
  assign run    = busy_d && !load;

  // hist[k] holds tx from k+1 cycles ago and rx_q holds rx from one cycle ago,
  // so a combinational rx=tx loop lines up with hist[0], i.e. latency 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q <= '0;
      for (int k = 0; k <= MAX_LAT; k++) hist[k] <= '0;
    end else begin
      rx_q    <= rx;
      hist[0] <= tx;
      for (int k = 1; k <= MAX_LAT; k++) hist[k] <= hist[k-1];
    end
  end

  // Pick the history tap for the latency under test (or the locked one).
  always_comb begin
    hist_sel = hist[0];
    for (int k = 0; k <= MAX_LAT; k++) begin
      if (lat_q == 5'(k)) hist_sel = hist[k];
    end
  end

  assign hit = (rx_q == hist_sel);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and next datapath values. Stop wins over start when busy; start
  // from an idle state clears every result before the new run. FILL lasts
  // MAX_LAT+1 cycles so every history tap holds a word of the new run before
  // ALIGN looks at it. ALIGN walks lat upward one step per mismatch.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    fill_d    = fill_q;
    match_d   = match_q;
    locked_d  = locked;
    fail_d    = fail;
    latency_d = latency;
    err_d     = err_count;
    word_d    = word_count;
    load      = 1'b0;

    if (busy && stop) begin
      state_d = DONE;
    end else if (start && !busy) begin
      state_d   = FILL;
      load      = 1'b1;
      lat_d     = '0;
      fill_d    = '0;
      match_d   = '0;
      locked_d  = 1'b0;
      fail_d    = 1'b0;
      latency_d = '0;
      err_d     = '0;
      word_d    = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (fill_q == 5'(MAX_LAT)) begin
            state_d = ALIGN;
            lat_d   = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        ALIGN: begin
          if (hit) begin
            if (match_q == MW'(ALIGN_MATCH - 1)) begin
              state_d   = CHECK;
              locked_d  = 1'b1;
              latency_d = lat_q;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
            if (lat_q == 5'(MAX_LAT)) begin
              state_d   = FAIL;
              fail_d    = 1'b1;
              latency_d = 5'(MAX_LAT);
            end else begin
              lat_d = lat_q + 5'd1;
            end
          end
        end
        CHECK: begin
          if (word_count != '1) word_d = word_count + CNT_W'(1);
          if (!hit && (err_count != '1)) err_d = err_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q      <= '0;
      fill_q     <= '0;
      match_q    <= '0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      latency    <= '0;
      err_count  <= '0;
      word_count <= '0;
    end else begin
      lat_q      <= lat_d;
      fill_q     <= fill_d;
      match_q    <= match_d;
      locked     <= locked_d;
      fail       <= fail_d;
      latency    <= latency_d;
      err_count  <= err_d;
      word_count <= word_d;
    end
  end

endmodule
